// File: rtl/img_pkg.sv
// Shared constants and pixel types for the greyscale conversion pipeline.
package img_pkg;

    localparam int RGB_W  = 12;
    localparam int CH_W   = 4;
    localparam int GREY_W = 4;
    localparam int ACC_W  = 12;

    localparam logic [ACC_W-1:0] COEF_R   = 12'd77;
    localparam logic [ACC_W-1:0] COEF_G   = 12'd150;
    localparam logic [ACC_W-1:0] COEF_B   = 12'd29;
    localparam logic [ACC_W-1:0] COEF_AVG = 12'd85;
    localparam logic [ACC_W-1:0] ROUND    = 12'd128;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb12_t;

endpackage

// File: rtl/pix_counter.sv
// Column/row position tracker; flags the final pixel of each frame at input transfer.
module pix_counter #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic last
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_end;
    logic             row_end;

    assign col_end = (col == COL_MAX);
    assign row_end = (row == ROW_MAX);
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_to_grey.sv
// Two-stage RGB444 to 4-bit grey converter with valid/ready flow control and end-of-frame tagging.
module rgb_to_grey
    import img_pkg::*;
#(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int LUMA_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RGB_W-1:0]  pixel_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [GREY_W-1:0] pixel_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    rgb12_t           px;
    logic             advance;
    logic             last_flag;
    logic [5:0]       chan_sum;
    logic [ACC_W-1:0] prod_r;
    logic [ACC_W-1:0] prod_g;
    logic [ACC_W-1:0] prod_b;
    logic [ACC_W-1:0] s1_r;
    logic [ACC_W-1:0] s1_g;
    logic [ACC_W-1:0] s1_b;
    logic             s1_valid;
    logic             s1_last;
    logic [ACC_W-1:0] sum;

    assign px       = pixel_in;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    pix_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pix_counter (
        .clk  (clk),
        .rst  (rst),
        .step (in_valid && advance),
        .last (last_flag)
    );

    assign chan_sum = {2'b00, px.r} + {2'b00, px.g} + {2'b00, px.b};

    // Average mode folds the whole product into the R lane so stage 2 stays shared.
    always_comb begin
        prod_r = '0;
        prod_g = '0;
        prod_b = '0;
        if (LUMA_MODE != 0) begin
            prod_r = {8'b0, px.r} * COEF_R;
            prod_g = {8'b0, px.g} * COEF_G;
            prod_b = {8'b0, px.b} * COEF_B;
        end else begin
            prod_r = {6'b0, chan_sum} * COEF_AVG;
        end
    end

    // Coefficients sum to 256 (or 3*85=255), so the rounded total never exceeds 12 bits.
    assign sum = s1_r + s1_g + s1_b + ROUND;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r      <= '0;
            s1_g      <= '0;
            s1_b      <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            pixel_out <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance) begin
            s1_r      <= prod_r;
            s1_g      <= prod_g;
            s1_b      <= prod_b;
            s1_valid  <= in_valid;
            s1_last   <= in_valid && last_flag;
            pixel_out <= GREY_W'(sum >> 8);
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
        end
    end

endmodule

// File: tb/tb_rgb_to_grey.sv
// Bench for rgb_to_grey: luma and average instances share stimulus and are checked against a queue model.
module tb_rgb_to_grey;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int FRAME = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pixel_in;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready_l, in_ready_a;
    logic [3:0]  pixel_out_l, pixel_out_a;
    logic        out_valid_l, out_valid_a;
    logic        out_last_l, out_last_a;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    always #5 clk = ~clk;

    rgb_to_grey #(.IMG_W(W), .IMG_H(H), .LUMA_MODE(1)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_ready(in_ready_l), .pixel_out(pixel_out_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_last(out_last_l)
    );

    rgb_to_grey #(.IMG_W(W), .IMG_H(H), .LUMA_MODE(0)) dut_avg (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_ready(in_ready_a), .pixel_out(pixel_out_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_last(out_last_a)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grey(input logic [11:0] p, input bit luma);
        int r, g, b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        if (luma) return (77 * r + 150 * g + 29 * b + 128) / 256;
        return (85 * (r + g + b) + 128) / 256;
    endfunction

    typedef struct {
        int gl;
        int ga;
        int last;
    } exp_t;

    exp_t q[$];
    int   midx = 0;
    bit   hold_prev = 0;
    int   prev_l, prev_a, prev_last;

    // Compare process: transfers are judged on the falling edge, ahead of the rising edge that commits them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            midx      = 0;
            hold_prev = 0;
        end else begin
            chk("valid_match", int'(out_valid_l), int'(out_valid_a));
            chk("ready_match", int'(in_ready_l), int'(in_ready_a));
            if (hold_prev) begin
                chk("stall_valid", int'(out_valid_l), 1);
                chk("stall_pix_l", int'(pixel_out_l), prev_l);
                chk("stall_pix_a", int'(pixel_out_a), prev_a);
                chk("stall_last", int'(out_last_l), prev_last);
            end
            if (out_valid_l && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("grey_luma", int'(pixel_out_l), e.gl);
                    chk("grey_avg", int'(pixel_out_a), e.ga);
                    chk("last_luma", int'(out_last_l), e.last);
                    chk("last_avg", int'(out_last_a), e.last);
                end
            end
            if (in_valid && in_ready_l) begin
                e.gl   = model_grey(pixel_in, 1'b1);
                e.ga   = model_grey(pixel_in, 1'b0);
                e.last = (midx == FRAME - 1) ? 1 : 0;
                q.push_back(e);
                midx = (midx + 1) % FRAME;
                n_acc++;
            end
            hold_prev = out_valid_l && !out_ready;
            prev_l    = int'(pixel_out_l);
            prev_a    = int'(pixel_out_a);
            prev_last = int'(out_last_l);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid_l), 0);
        chk("rst_out_last", int'(out_last_l), 0);
        chk("rst_pixel_out", int'(pixel_out_l), 0);
        chk("rst_in_ready", int'(in_ready_l), 1);
    endtask

    // Single pixel with out_ready high: must be on the output exactly two edges after acceptance.
    task automatic send_direct(input logic [11:0] pix, input int exp_l, input int exp_a);
        in_valid = 1'b1;
        pixel_in = pix;
        tick();
        in_valid = 1'b0;
        tick();
        chk("lat_valid", int'(out_valid_l), 1);
        chk("lat_luma", int'(pixel_out_l), exp_l);
        chk("lat_avg", int'(pixel_out_a), exp_a);
    endtask

    // Streams n pixels with out_ready high and returns how many outputs and which output indices carried last.
    task automatic stream_lasts(input int n, output int ocount, output int nlast, output int at_a, output int at_b);
        ocount = 0;
        nlast  = 0;
        at_a   = 0;
        at_b   = 0;
        for (int i = 0; i < n + 2; i++) begin
            in_valid = (i < n);
            pixel_in = 12'($urandom_range(0, 4095));
            if (out_valid_l) begin
                ocount++;
                if (out_last_l) begin
                    nlast++;
                    if (ocount == FRAME)     at_a = 1;
                    if (ocount == 2 * FRAME) at_b = 1;
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int oc, nl, la, lb, cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        pixel_in  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        do_reset();

        chk("model_pin_f00", model_grey(12'hF00, 1'b1), 5);
        chk("model_pin_888a", model_grey(12'h888, 1'b0), 8);

        send_direct(12'hFFF, 15, 15);
        send_direct(12'h000, 0, 0);
        send_direct(12'hF00, 5, 5);
        send_direct(12'h0F0, 9, 5);
        send_direct(12'h00F, 2, 5);
        send_direct(12'h888, 8, 8);
        tick();

        in_valid = 1'b1;
        pixel_in = 12'h0F0;
        tick();
        pixel_in = 12'hF00;
        tick();
        in_valid  = 1'b0;
        chk("bp_first", int'(pixel_out_l), 9);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_pix", int'(pixel_out_l), 9);
            chk("bp_hold_valid", int'(out_valid_l), 1);
            chk("bp_in_ready", int'(in_ready_l), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_valid", int'(out_valid_l), 1);
        chk("bp_next_pix", int'(pixel_out_l), 5);
        tick();
        chk("bp_drained", int'(out_valid_l), 0);

        do_reset();
        stream_lasts(2 * FRAME, oc, nl, la, lb);
        chk("frame_outputs", oc, 2 * FRAME);
        chk("frame_last_count", nl, 2);
        chk("frame_last_8", la, 1);
        chk("frame_last_16", lb, 1);

        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pixel_in = 12'($urandom_range(0, 4095));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_valid", int'(out_valid_l), 0);
        chk("midreset_ready", int'(in_ready_l), 1);
        stream_lasts(FRAME, oc, nl, la, lb);
        chk("postrst_outputs", oc, FRAME);
        chk("postrst_last_count", nl, 1);
        chk("postrst_last_at_end", la, 1);

        do_reset();
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            pixel_in  = 12'($urandom_range(0, 4095));
            tick();
            cyc++;
        end
        chk("random_budget", int'(n_acc >= 10000), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("drain_empty", q.size(), 0);
        tick();
        chk("idle_valid", int'(out_valid_l), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
